gaussian_window_3x3: RTL and testbench
======================================

# gaussian_window_3x3

Downstream consumer of the double line buffer: takes the three vertically aligned row taps (current row, one line back, two lines back) and assembles a sliding 3x3 pixel window. It applies the 3x3 Gaussian kernel [1 2 1; 2 4 2; 1 2 1]/16 with rounding, and emits one filtered 8-bit pixel per valid window. It tracks column and row position, suppresses horizontally incomplete windows at each line start, and flags the last pixel of a frame.

## Interface
- IMG_WIDTH, 640, pixels per line; must be ≥ 3.
- IMG_HEIGHT, 480, lines per frame; must be ≥ 3.
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- clear_i  input  1  synchronous clear of counters, window and pipeline valids; priority over valid_i.
- valid_i  input  1  row taps valid this cycle; driven by the line buffer's done_o.
- row0_i  input  8  current-row pixel (newest line).
- row1_i  input  8  pixel one line above.
- row2_i  input  8  pixel two lines above (oldest line).
- pixel_o  output  8  filtered pixel.
- valid_o  output  1  pixel_o valid this cycle.
- frame_done_o  output  1  one-cycle pulse coincident with the last valid_o of a frame.

## Operation
- Window: 3 rows x 3 columns of 8-bit registers, w[r][0..2].
  - On valid_i: w[r][2]<=w[r][1]; w[r][1]<=w[r][0]; w[r][0]<=row{r}_i.
  - Without valid_i, the window holds.
- col_cnt (0..IMG_WIDTH-1): increments on each valid_i and wraps to 0 after IMG_WIDTH-1.
- row_cnt (0..IMG_HEIGHT-3): increments on the col_cnt wrap and wraps to 0 after IMG_HEIGHT-3.
  - The upstream line buffer delivers IMG_HEIGHT-2 lines per frame.
- Window valid: an accepted valid_i with col_cnt ≥ 2 (pre-increment value).
  - Yields IMG_WIDTH-2 outputs per line and (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs per frame.
  - Windows never straddle lines: the first two samples of every line only fill the window.
- Last flag: accepted valid_i with col_cnt==IMG_WIDTH-1 and row_cnt==IMG_HEIGHT-3. It travels with the window valid.
- Arithmetic (unsigned):
  - Stage B, per row r: s_r = w[r][0] + 2*w[r][1] + w[r][2]. 10 bits, max 1020.
  - Stage C: t = s0 + 2*s2... specifically t = s_row0 + 2*s_row1 + s_row2 + 8. 13 bits, max 4088.
  - pixel_o = t[11:4]. Rounds half up, cannot exceed 255, no saturation logic needed.
- No backpressure: the consumer must accept every valid_o.
- Gaps in valid_i are permitted anywhere. In-flight pipeline stages still drain.

## Timing
- Pipeline has 3 register stages:
  - Edge E0 (sampling valid_i): window shift plus window-valid/last flags.
  - Edge E1: row sums.
  - Edge E2: pixel_o, valid_o, frame_done_o.
- Latency: valid_o is high in the cycle after E2, i.e. 2 clocks after the sampling edge.
- Throughput: 1 pixel/clock with valid_i held high.
- Reset (rst low, asynchronous): all window regs, sums, counters and flags go to 0.
  - pixel_o=0, valid_o=0, frame_done_o=0 immediately, without waiting for a clock edge.
- Reset mid-line or mid-frame: in-flight pixels are discarded. The next valid_i after release is treated as column 0, row 0.
- clear_i: same effect as reset, but synchronous, at the next edge.
  - An input with valid_i in the same cycle is dropped.
  - Outputs already registered at E2 remain visible for that one cycle.
- Wrap: at the frame-last sample, col_cnt and row_cnt both return to 0 on the same edge.
  - The next frame starts immediately with no idle cycle required.
- frame_done_o is high only alongside valid_o, never on its own.

## Test plan
Use IMG_WIDTH=8 and IMG_HEIGHT=6 for all scenarios.
- Flat field: all taps = 100, valid_i continuous for 4 lines of 8.
  - Expect 24 valid_o, each with pixel_o=100.
  - Expect 6 per line; no valid_o during the first 2 samples of each line.
  - Expect frame_done_o on the 24th output only.
- Full scale: all taps = 255 → every pixel_o=255, with no wrap or overflow.
- Impulse: a single 255 at row1, column 3, all other pixels 0.
  - Outputs for columns 2,3,4 (centre at col 3) = 32, 64, 32.
  - Impulse moved to row0 → outputs 16, 32, 16.
- Latency and stalls: insert valid_i low for 3 cycles mid-line.
  - valid_o stays exactly 2 clocks after each qualifying sample.
  - Output values match the unstalled run.
  - The output count per line stays at 6.
- Reset mid-frame: assert rst low asynchronously after 13 samples.
  - All outputs read 0 immediately.
  - After release, a full frame again yields exactly 24 outputs and one frame_done_o.
- Back-to-back frames with clear_i:
  - Two frames with no gap → 48 outputs and 2 frame_done_o pulses.
  - clear_i asserted mid-frame → the counters restart and the next line produces its first output on its 3rd sample.

Source files
------------

// File: rtl/gaussian_window_3x3_if.sv
// Stream bundle between the line buffer taps and the 3x3 Gaussian window filter.
// The slave side is the filter; the master side drives the row taps.
interface gaussian_window_3x3_if;
    logic       clear_i;
    logic       valid_i;
    logic [7:0] row0_i;
    logic [7:0] row1_i;
    logic [7:0] row2_i;
    logic [7:0] pixel_o;
    logic       valid_o;
    logic       frame_done_o;

    modport master (
        output clear_i, valid_i, row0_i, row1_i, row2_i,
        input  pixel_o, valid_o, frame_done_o
    );

    modport slave (
        input  clear_i, valid_i, row0_i, row1_i, row2_i,
        output pixel_o, valid_o, frame_done_o
    );
endinterface

// File: rtl/gaussian_window_3x3.sv
// Sliding 3x3 window over three aligned row taps, filtered by [1 2 1; 2 4 2; 1 2 1]/16
// with round-half-up; one output per horizontally complete window, last-of-frame flagged.
module gaussian_window_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    gaussian_window_3x3_if.slave  bus
);
    localparam int DATA_W = 8;
    localparam int SUM_W  = DATA_W + 2;
    localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 3);

    function automatic logic [SUM_W-1:0] f_row_sum(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic [DATA_W-1:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // Max weighted total is 4088, so the rounded result never exceeds 255.
    function automatic logic [DATA_W-1:0] f_round(input logic [SUM_W-1:0] s0,
                                                  input logic [SUM_W-1:0] s1,
                                                  input logic [SUM_W-1:0] s2);
        logic [SUM_W+2:0] t;
        t = {3'b000, s0} + {2'b00, s1, 1'b0} + {3'b000, s2} + (SUM_W+3)'(8);
        return DATA_W'(t >> 4);
    endfunction

    logic [DATA_W-1:0] r_win_p0 [3][3];
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic              r_vld_p0, r_last_p0;
    logic [SUM_W-1:0]  r_sum_p1 [3];
    logic              r_vld_p1, r_last_p1;
    logic [DATA_W-1:0] r_pix_p2;
    logic              r_vld_p2, r_last_p2;
    logic [DATA_W-1:0] w_taps [3];

    assign w_taps[0] = bus.row0_i;
    assign w_taps[1] = bus.row1_i;
    assign w_taps[2] = bus.row2_i;

    // Stage p0: window shift, position counters, window-valid and last flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    r_win_p0[r][c] <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_vld_p0  <= 1'b0;
            r_last_p0 <= 1'b0;
        end else if (bus.clear_i) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    r_win_p0[r][c] <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_vld_p0  <= 1'b0;
            r_last_p0 <= 1'b0;
        end else begin
            r_vld_p0  <= 1'b0;
            r_last_p0 <= 1'b0;
            if (bus.valid_i) begin
                for (int r = 0; r < 3; r++) begin
                    r_win_p0[r][2] <= r_win_p0[r][1];
                    r_win_p0[r][1] <= r_win_p0[r][0];
                    r_win_p0[r][0] <= w_taps[r];
                end
                r_vld_p0  <= (r_col >= COL_W'(2));
                r_last_p0 <= (r_col == COL_LAST) && (r_row == ROW_LAST);
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

    // Stage p1: horizontal [1 2 1] sum per window row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 3; r++)
                r_sum_p1[r] <= '0;
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
        end else if (bus.clear_i) begin
            for (int r = 0; r < 3; r++)
                r_sum_p1[r] <= '0;
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
        end else begin
            for (int r = 0; r < 3; r++)
                r_sum_p1[r] <= f_row_sum(r_win_p0[r][0], r_win_p0[r][1], r_win_p0[r][2]);
            r_vld_p1  <= r_vld_p0;
            r_last_p1 <= r_last_p0;
        end
    end

    // Stage p2: vertical [1 2 1] combine, round, register outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_p2  <= '0;
            r_vld_p2  <= 1'b0;
            r_last_p2 <= 1'b0;
        end else if (bus.clear_i) begin
            r_pix_p2  <= '0;
            r_vld_p2  <= 1'b0;
            r_last_p2 <= 1'b0;
        end else begin
            r_pix_p2  <= f_round(r_sum_p1[0], r_sum_p1[1], r_sum_p1[2]);
            r_vld_p2  <= r_vld_p1;
            r_last_p2 <= r_last_p1 & r_vld_p1;
        end
    end

    assign bus.pixel_o      = r_pix_p2;
    assign bus.valid_o      = r_vld_p2;
    assign bus.frame_done_o = r_last_p2;
endmodule

// File: tb/tb_gaussian_window_3x3.sv
// Randomized and directed bench for gaussian_window_3x3 against a per-line image model
// that applies the 3x3 Gaussian kernel directly from stored column samples.
module tb_gaussian_window_3x3;
    localparam int W = 8;
    localparam int H = 6;

    typedef struct {
        int due;
        int pix;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    gaussian_window_3x3_if bus();

    gaussian_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   m_col  = 0;
    int   m_row  = 0;
    int   n_out  = 0;
    int   n_fd   = 0;
    int   img [3][W];
    exp_t q [$];
    int   got [$];

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        checks++;
        assert (obs === 32'(expv))
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int wt(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int tap(input int mode, input int r, input int c);
        case (mode)
            0:       return 100;
            1:       return 255;
            2:       return (r == 1 && c == 3) ? 255 : 0;
            3:       return (r == 0 && c == 3) ? 255 : 0;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // Reference: keep each line's taps by column; a window centred on column c-1
    // exists once column c >= 2 has arrived in the same line.
    task automatic model(input bit v, input bit clr, input int a, input int b, input int c);
        int s;
        if (clr) begin
            q.delete();
            m_col = 0;
            m_row = 0;
        end else if (v) begin
            img[0][m_col] = a;
            img[1][m_col] = b;
            img[2][m_col] = c;
            if (m_col >= 2) begin
                s = 0;
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        s += wt(dr) * wt(dc) * img[dr][m_col - 2 + dc];
                q.push_back('{cyc + 2, (s + 8) / 16, (m_col == W - 1) && (m_row == H - 3)});
            end
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 3) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("valid_o", bus.valid_o, 1);
            chk("pixel_o", bus.pixel_o, e.pix);
            chk("frame_done_o", bus.frame_done_o, int'(e.last));
        end else begin
            chk("valid_o_idle", bus.valid_o, 0);
            chk("frame_done_o_idle", bus.frame_done_o, 0);
        end
        if (bus.valid_o === 1'b1) begin
            n_out++;
            got.push_back(int'(bus.pixel_o));
        end
        if (bus.frame_done_o === 1'b1) n_fd++;
    endtask

    task automatic step(input bit v, input bit clr, input int a, input int b, input int c);
        bus.valid_i = v;
        bus.clear_i = clr;
        bus.row0_i  = 8'(a);
        bus.row1_i  = 8'(b);
        bus.row2_i  = 8'(c);
        @(posedge clk);
        cyc++;
        model(v, clr, a, b, c);
        @(negedge clk);
        check_out();
    endtask

    task automatic feed_line(input int mode, input bit stall, input int idle);
        for (int c = 0; c < W; c++) begin
            step(1'b1, 1'b0, tap(mode, 0, c), tap(mode, 1, c), tap(mode, 2, c));
            if (stall && c == 4) repeat (3) step(1'b0, 1'b0, 0, 0, 0);
        end
        repeat (idle) step(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic line_chk(input int mode, input bit stall, input string tag);
        int n0;
        n0 = n_out;
        feed_line(mode, stall, 2);
        chk(tag, n_out - n0, W - 2);
    endtask

    initial begin
        int n0, f0;
        rst         = 1'b0;
        bus.clear_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.row0_i  = '0;
        bus.row1_i  = '0;
        bus.row2_i  = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid_o", bus.valid_o, 0);
        chk("reset_pixel_o", bus.pixel_o, 0);
        chk("reset_frame_done_o", bus.frame_done_o, 0);
        rst = 1'b1;

        // Flat 100 frame followed immediately by a full-scale frame
        n0 = n_out;
        f0 = n_fd;
        got.delete();
        repeat (H - 2) feed_line(0, 1'b0, 0);
        repeat (H - 2) feed_line(1, 1'b0, 0);
        repeat (2) step(1'b0, 1'b0, 0, 0, 0);
        chk("two_frames_outputs", n_out - n0, 48);
        chk("two_frames_done", n_fd - f0, 2);
        chk("flat_first", got[0], 100);
        chk("flat_last", got[23], 100);
        chk("full_first", got[24], 255);
        chk("full_last", got[47], 255);

        // Impulse in the middle row, then in the newest row
        f0 = n_fd;
        got.delete();
        line_chk(2, 1'b0, "imp_row1_count");
        chk("imp_row1_c1", got[0], 0);
        chk("imp_row1_c2", got[1], 32);
        chk("imp_row1_c3", got[2], 64);
        chk("imp_row1_c4", got[3], 32);
        chk("imp_row1_c5", got[4], 0);
        got.delete();
        line_chk(3, 1'b0, "imp_row0_count");
        chk("imp_row0_c2", got[1], 16);
        chk("imp_row0_c3", got[2], 32);
        chk("imp_row0_c4", got[3], 16);

        // Mid-line stall, then the frame's last line
        line_chk(4, 1'b1, "stall_line_count");
        line_chk(4, 1'b0, "rand_line_count");
        chk("frame_c_done", n_fd - f0, 1);

        // Asynchronous reset after 13 samples
        for (int i = 0; i < 13; i++)
            step(1'b1, 1'b0, tap(4, 0, 0), tap(4, 1, 0), tap(4, 2, 0));
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid_o", bus.valid_o, 0);
        chk("async_rst_pixel_o", bus.pixel_o, 0);
        chk("async_rst_frame_done_o", bus.frame_done_o, 0);
        q.delete();
        m_col = 0;
        m_row = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b1;
        n0 = n_out;
        f0 = n_fd;
        repeat (H - 2) line_chk(4, 1'b0, "post_rst_line_count");
        chk("post_rst_outputs", n_out - n0, 24);
        chk("post_rst_done", n_fd - f0, 1);

        // Synchronous clear mid-frame with a coincident (dropped) sample
        for (int i = 0; i < 11; i++)
            step(1'b1, 1'b0, tap(4, 0, 0), tap(4, 1, 0), tap(4, 2, 0));
        step(1'b1, 1'b1, 255, 255, 255);
        line_chk(4, 1'b0, "post_clear_line_count");
        n0 = n_out;
        f0 = n_fd;
        repeat (H - 3) line_chk(4, 1'b0, "post_clear_rest_count");
        chk("post_clear_frame_done", n_fd - f0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
